fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the opcode/funct decoder.
- Owns the program counter, drives the instruction-memory address, and registers fetched words into an IF/ID register whose opcode and funct fields feed the decoder.
- Accepts the decoder's Jump, JumpSel and Branch outputs, plus the ALU zero flag, to redirect the PC, flushing the wrong-path instruction.
- Supports load-use stall and halts on SYSCALL.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush, boot and halt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (hazard unit).
- Jump  in  1  decoder: unconditional jump for the ID instruction.
- JumpSel  in  1  decoder: 0 = J/JAL target from instr[25:0]; 1 = JR target from rs_data.
- Branch  in  1  decoder: ID instruction is BNE.
- zero  in  1  ALU zero flag for the BNE compare.
- rs_data  in  32  register-file rs value (JR target).
- imem_addr  out  32  instruction-memory address; equals pc.
- imem_data  in  32  instruction word; combinational read of imem_addr.
- pc  out  32  current fetch PC.
- id_instr  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4 (JAL link value, branch base).
- opcode  out  6  id_instr[31:26].
- funct  out  6  id_instr[5:0].
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  SYSCALL reached; fetch stopped.

Behaviour:
- Reset, asynchronous, active-high: pc=RESET_PC, id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0, halted=0, state=BOOT.
  - Reset asserted mid-operation overrides everything immediately, including a pending redirect or HALT.
- States:
  - BOOT: one cycle with IF/ID=NOP, id_valid=0 and pc unchanged, then go to RUN. This lets the memory address settle after reset.
  - RUN: normal fetch.
  - HALT: terminal until reset.
- RUN, per rising edge, in priority order:
  1. Redirect. Taken when Jump=1, or when Branch=1 and zero=0 (BNE taken), and id_valid=1.
     - pc gets the target.
     - IF/ID gets NOP_WORD with id_valid=0 (one-bubble flush).
     - Redirect beats stall when both are asserted.
  2. Halt. Taken when id_valid=1, opcode=0 and funct=6'b001100.
     - State goes to HALT, halted=1.
     - pc is frozen; IF/ID gets NOP with id_valid=0.
  3. Stall: pc, id_instr, id_pc_plus4 and id_valid all hold.
  4. Otherwise:
     - pc = pc+4.
     - id_instr = imem_data, id_pc_plus4 = pc+4, id_valid=1.
- Targets (32-bit, wrap modulo 2^32, no overflow flag):
  - J/JAL: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - JR: rs_data, used as-is with no alignment check.
  - BNE: id_pc_plus4 + (sign_extend(id_instr[15:0]) << 2).
- Jump, Branch and zero are ignored while id_valid=0, so they cannot redirect from a bubble.
- In HALT, stall, Jump and Branch are ignored and the outputs stay constant.
- opcode and funct are pure slices of id_instr, so they update in the same cycle as id_instr.
- Latency: a word fetched at pc appears on id_instr one edge later. A redirect costs exactly one bubble.

Decomposition:
- Shared package holds:
  - opcode constants: LW, SW, J, JAL, BNE, XORI, RTYPE=0.
  - funct constants: JR, ADD, SUB, SLT, SYSCALL.
  - NOP_WORD and the fetch-state enum: BOOT, RUN, HALT.
- One sub-module, next_pc, is natural. It is combinational: inputs are pc, id_instr, id_pc_plus4, rs_data and the redirect selects; outputs are the target and the redirect flag.
- The PC/IF-ID registers and the FSM stay in the top module.

Test Plan:
- Reset then sequential fetch:
  - Setup: reset pulsed, memory words at 0, 4, 8.
  - Required: cycle 1 in BOOT with id_valid=0; then id_instr takes word@0, word@4 and word@8 on successive edges; pc=0,4,8,12.
- J redirect:
  - Stimulus: ID holds J target field 26'h40 at id_pc_plus4=32'h8, with Jump=1, JumpSel=0.
  - Required: next pc=32'h100; id_valid=0 for one cycle; then id_instr=word@0x100.
- BNE taken vs not taken:
  - Stimulus: imm=16'hFFFE, id_pc_plus4=32'h20, Branch=1.
  - Required with zero=0: pc=32'h18 and one bubble.
  - Required with zero=1: pc continues +4 with no bubble.
- JR with simultaneous stall:
  - Stimulus: rs_data=32'h3C, Jump=1, JumpSel=1, stall=1.
  - Required: pc=32'h3C (redirect wins); IF/ID is flushed.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles mid-stream.
  - Required: pc, id_instr and id_valid are unchanged for 3 edges; fetch then resumes at the held pc+4.
- SYSCALL and reset out of HALT:
  - Stimulus: id_instr=32'h0000_000C.
  - Required: halted=1 next edge; pc frozen; later Jump=1 is ignored.
  - Then assert reset asynchronously between edges: pc=RESET_PC and halted=0 immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode/funct encodings,
// the NOP word and the fetch-state enum.
package fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  function automatic logic is_syscall(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_SYSCALL);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory bus, decoder/hazard controls and the
// IF/ID register outputs. master = fetch unit, slave = surrounding pipeline.
interface fetch_unit_if;
  logic        stall;
  logic        Jump;
  logic        JumpSel;
  logic        Branch;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        id_valid;
  logic        halted;

  modport master (
    input  stall, Jump, JumpSel, Branch, zero, rs_data, imem_data,
    output imem_addr, pc, id_instr, id_pc_plus4, opcode, funct, id_valid, halted
  );

  modport slave (
    output stall, Jump, JumpSel, Branch, zero, rs_data, imem_data,
    input  imem_addr, pc, id_instr, id_pc_plus4, opcode, funct, id_valid, halted
  );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC logic: sequential PC+4 plus the J/JAL, JR and BNE
// redirect targets and the redirect decision for the instruction in ID.
module fetch_unit_next_pc (
  input  logic [31:0] pc,
  input  logic [25:0] id_instr_idx,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] rs_data,
  input  logic        id_valid,
  input  logic        jump,
  input  logic        jump_sel,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] seq_pc,
  output logic [31:0] target,
  output logic        redirect
);

  logic [31:0] j_target;
  logic [31:0] br_target;

  assign seq_pc    = pc + 32'd4;
  assign j_target  = {id_pc_plus4[31:28], id_instr_idx, 2'b00};
  // Immediate sits in the low 16 bits of the index field for I-type words.
  assign br_target = id_pc_plus4 + {{14{id_instr_idx[15]}}, id_instr_idx[15:0], 2'b00};

  // A bubble in ID must never redirect, whatever the decoder lines say.
  assign redirect = id_valid & (jump | (branch & ~zero));

  always_comb begin
    target = br_target;
    if (jump) target = jump_sel ? rs_data : j_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID register and BOOT/RUN/HALT
// control, redirected by jumps and taken BNEs from the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = fetch_unit_pkg::NOP_WORD
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pp4_q, pp4_d;
  logic         valid_q, valid_d;

  logic [31:0]  seq_pc;
  logic [31:0]  target;
  logic         redirect;

  fetch_unit_next_pc u_next_pc (
    .pc           (pc_q),
    .id_instr_idx (instr_q[25:0]),
    .id_pc_plus4  (pp4_q),
    .rs_data      (bus.rs_data),
    .id_valid     (valid_q),
    .jump         (bus.Jump),
    .jump_sel     (bus.JumpSel),
    .branch       (bus.Branch),
    .zero         (bus.zero),
    .seq_pc       (seq_pc),
    .target       (target),
    .redirect     (redirect)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pp4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a hold default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_BOOT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Redirect outranks stall: the wrong-path word is flushed either way.
          pc_d    = target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (valid_q && is_syscall(instr_q)) begin
          state_d = ST_HALT;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          pc_d    = seq_pc;
          instr_d = bus.imem_data;
          pp4_d   = seq_pc;
          valid_d = 1'b1;
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc_plus4 = pp4_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.id_valid    = valid_q;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized control
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr[9:2]];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_boot, m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       bus.pc,          m_pc);
    check({tag, ".addr"},     bus.imem_addr,   m_pc);
    check({tag, ".instr"},    bus.id_instr,    m_instr);
    check({tag, ".pp4"},      bus.id_pc_plus4, m_pp4);
    check({tag, ".opcode"},   32'(bus.opcode), 32'(m_instr[31:26]));
    check({tag, ".funct"},    32'(bus.funct),  32'(m_instr[5:0]));
    check({tag, ".valid"},    32'(bus.id_valid), 32'(m_valid));
    check({tag, ".halted"},   32'(bus.halted),   32'(m_halted));
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'd0 && w[5:0] == 6'd12) w[0] = ~w[0];
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = rnd_word();
  endtask

  // Reset asserted away from any clock edge; DUT must respond without an edge.
  task automatic do_reset();
    bus.stall = 1'b0; bus.Jump = 1'b0; bus.JumpSel = 1'b0;
    bus.Branch = 1'b0; bus.zero = 1'b0; bus.rs_data = 32'h0;
    reset = 1'b1;
    #1;
    m_pc = RESET_PC; m_instr = 32'h0; m_pp4 = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_halted = 1'b0;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: apply controls, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic s, input logic j, input logic js,
                      input logic b, input logic z, input logic [31:0] rs);
    logic [31:0] fetched;
    bus.stall = s; bus.Jump = j; bus.JumpSel = js;
    bus.Branch = b; bus.zero = z; bus.rs_data = rs;
    fetched = mem[m_pc[9:2]];
    if (m_halted) begin
      // frozen until reset
    end else if (m_boot) begin
      m_boot = 1'b0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (m_valid && (j || (b && !z))) begin
      if (j && js)  m_pc = rs;
      else if (j)   m_pc = (m_pp4 & 32'hF000_0000) | (32'(m_instr[25:0]) * 32'd4);
      else          m_pc = m_pp4 + 32'($signed(m_instr[15:0])) * 32'd4;
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (m_valid && m_instr[31:26] == 6'd0 && m_instr[5:0] == 6'd12) begin
      m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = fetched; m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    fill_mem();
    mem[0]  = 32'h2008_0001;
    mem[1]  = 32'h0800_0040;   // J, target field 26'h40
    mem[7]  = 32'h1485_FFFE;   // BNE, imm -2
    mem[20] = 32'h0000_000C;   // SYSCALL

    // Reset then sequential fetch
    do_reset();
    idle();
    check("boot.pc", bus.pc, 32'h0);
    check("boot.valid", 32'(bus.id_valid), 32'h0);
    idle();
    check("seq0.instr", bus.id_instr, mem[0]);
    check("seq0.pc", bus.pc, 32'h4);
    idle();
    check("seq1.instr", bus.id_instr, mem[1]);
    check("seq1.pc", bus.pc, 32'h8);
    idle();
    check("seq2.instr", bus.id_instr, mem[2]);
    check("seq2.pc", bus.pc, 32'hC);

    // J redirect from id_pc_plus4 = 8
    do_reset();
    repeat (3) idle();
    check("j.pp4", bus.id_pc_plus4, 32'h8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("j.pc", bus.pc, 32'h100);
    check("j.bubble", 32'(bus.id_valid), 32'h0);
    idle();
    check("j.instr", bus.id_instr, mem[64]);
    check("j.valid", 32'(bus.id_valid), 32'h1);

    // BNE taken
    do_reset();
    repeat (9) idle();
    check("bne.pp4", bus.id_pc_plus4, 32'h20);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("bne_t.pc", bus.pc, 32'h18);
    check("bne_t.bubble", 32'(bus.id_valid), 32'h0);
    idle();
    check("bne_t.instr", bus.id_instr, mem[6]);

    // BNE not taken
    do_reset();
    repeat (9) idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    check("bne_nt.pc", bus.pc, 32'h24);
    check("bne_nt.valid", 32'(bus.id_valid), 32'h1);
    check("bne_nt.instr", bus.id_instr, mem[8]);

    // JR together with stall: redirect wins
    do_reset();
    repeat (3) idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3C);
    check("jr.pc", bus.pc, 32'h3C);
    check("jr.flush_valid", 32'(bus.id_valid), 32'h0);
    check("jr.flush_instr", bus.id_instr, 32'h0);
    idle();
    idle();
    check("pre_stall.pc", bus.pc, 32'h44);

    // Stall hold for 3 edges
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("stall.pc", bus.pc, 32'h44);
      check("stall.instr", bus.id_instr, mem[16]);
      check("stall.valid", 32'(bus.id_valid), 32'h1);
    end
    idle();
    check("resume.pc", bus.pc, 32'h48);
    check("resume.instr", bus.id_instr, mem[17]);

    // Run into SYSCALL
    repeat (3) idle();
    check("sys.instr", bus.id_instr, 32'h0000_000C);
    idle();
    check("halt.halted", 32'(bus.halted), 32'h1);
    check("halt.pc", bus.pc, 32'h54);
    repeat (3) step(1'($urandom), 1'b1, 1'($urandom), 1'b1, 1'b0, 32'h80);
    check("halt.jump_ignored", bus.pc, 32'h54);

    // Asynchronous reset out of HALT, between edges
    #2;
    reset = 1'b1;
    #1;
    check("areset.pc", bus.pc, RESET_PC);
    check("areset.halted", 32'(bus.halted), 32'h0);
    @(negedge clk);

    // Randomized control stimulus against the model
    fill_mem();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
           ($urandom_range(0, 6) == 0), 1'($urandom),
           {22'h0, 8'($urandom_range(0, 255)), 2'b00});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
